// File: rtl/trigger_pattern_fifo.sv
// Buffers trigger patterns and issues one load strobe per converter idle window; 2-clock write-to-strobe latency.
// Writes lost when full (sticky overflow, drop_cnt); `TRIG_TAG_EN stores a 6-bit tag with each pattern.
module trigger_pattern_fifo #(
   parameter int DEPTH_LOG2 = 3,
   parameter bit DROP_EMPTY = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [3:0]            trig_in,
   input  logic                  trig_in_dv,
   output logic [3:0]            pattern_out,
   output logic                  pattern_dv,
   input  logic                  conv_busy,
   output logic                  fifo_empty,
   output logic                  fifo_full,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  overflow,
   output logic [15:0]           drop_cnt,
   output logic [15:0]           issued_cnt
`ifdef TRIG_TAG_EN
   ,
   input  logic [5:0]            trig_tag_in,
   output logic [5:0]            tag_out
`endif
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int LW    = DEPTH_LOG2 + 1;
   localparam logic [DEPTH_LOG2:0] FULL_LVL = LW'(DEPTH);
`ifdef TRIG_TAG_EN
   localparam int EW = 10;
`else
   localparam int EW = 4;
`endif

   typedef enum logic [1:0] {IDLE, ARM, WAIT} state_t;
   typedef logic [EW-1:0] entry_t;

   entry_t                mem_q [DEPTH];
   entry_t                wr_entry;
   entry_t                head;
   state_t                state_q;
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   level_q, level_d;
   logic                  empty_q, empty_d;
   logic                  full_q, full_d;
   logic                  overflow_q, overflow_d;
   logic [15:0]           drop_cnt_q, drop_cnt_d;
   logic [15:0]           issued_cnt_q, issued_cnt_d;
   logic [3:0]            pattern_q;
   logic                  pattern_dv_q;
   logic                  empty_pat;
   logic                  wr_en;
   logic                  lost;
   logic                  rd_en;

`ifdef TRIG_TAG_EN
   logic [5:0]            tag_q;
   assign wr_entry = {trig_tag_in, trig_in};
   assign tag_out  = tag_q;
`else
   assign wr_entry = trig_in;
`endif

   assign head      = mem_q[rd_ptr_q];
   assign empty_pat = DROP_EMPTY && (trig_in == 4'h0);
   // Full is the registered flag, so a same-cycle read never rescues a write to a full FIFO
   assign wr_en     = trig_in_dv && !full_q && !empty_pat;
   assign lost      = trig_in_dv && full_q && !empty_pat;
   assign rd_en     = (state_q == IDLE) && !empty_q && !conv_busy;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= wr_entry;
      end
   end

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      level_d      = level_q;
      overflow_d   = overflow_q | lost;
      drop_cnt_d   = drop_cnt_q;
      issued_cnt_d = issued_cnt_q;
      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      end
      if (rd_en) begin
         rd_ptr_d     = rd_ptr_q + DEPTH_LOG2'(1);
         issued_cnt_d = issued_cnt_q + 16'd1;
      end
      case ({wr_en, rd_en})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
      if (lost && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end
      empty_d = (level_d == '0);
      full_d  = (level_d == FULL_LVL);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         empty_q      <= 1'b1;
         full_q       <= 1'b0;
         overflow_q   <= 1'b0;
         drop_cnt_q   <= '0;
         issued_cnt_q <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         empty_q      <= empty_d;
         full_q       <= full_d;
         overflow_q   <= overflow_d;
         drop_cnt_q   <= drop_cnt_d;
         issued_cnt_q <= issued_cnt_d;
      end
   end

   // ARM covers the cycle in which the converter is still raising busy after the load
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         pattern_dv_q <= 1'b0;
         pattern_q    <= '0;
`ifdef TRIG_TAG_EN
         tag_q        <= '0;
`endif
      end else begin
         pattern_dv_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (rd_en) begin
                  pattern_dv_q <= 1'b1;
                  pattern_q    <= head[3:0];
`ifdef TRIG_TAG_EN
                  tag_q        <= head[9:4];
`endif
                  state_q      <= ARM;
               end
            end
            ARM:     state_q <= WAIT;
            WAIT:    if (!conv_busy) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign pattern_out = pattern_q;
   assign pattern_dv  = pattern_dv_q;
   assign fifo_empty  = empty_q;
   assign fifo_full   = full_q;
   assign level       = level_q;
   assign overflow    = overflow_q;
   assign drop_cnt    = drop_cnt_q;
   assign issued_cnt  = issued_cnt_q;

endmodule

// File: tb/tb_trigger_pattern_fifo.sv
// Directed bench for trigger_pattern_fifo with a busy-converter model and an issue-order scoreboard.
module tb_trigger_pattern_fifo;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  trig_in;
   logic        trig_in_dv;
   logic [3:0]  pattern_out;
   logic        pattern_dv;
   logic        conv_busy;
   logic        fifo_empty;
   logic        fifo_full;
   logic [3:0]  level;
   logic        overflow;
   logic [15:0] drop_cnt;
   logic [15:0] issued_cnt;
   logic [5:0]  trig_tag_in;
   logic [5:0]  tag_out;

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          busy_len = 16;
   int          busy_cnt;
   bit          hold_busy = 1'b0;
   logic [9:0]  exp_q[$];
   logic [9:0]  mon_e;
   int          strobes = 0;
   int          last_dv = -1000;
   logic [3:0]  last_out = 4'h0;
   int          peak = 0;
   int          s0;

   trigger_pattern_fifo #(.DEPTH_LOG2(3), .DROP_EMPTY(1'b1)) dut (
      .clk         (clk),
      .reset       (reset),
      .trig_in     (trig_in),
      .trig_in_dv  (trig_in_dv),
      .pattern_out (pattern_out),
      .pattern_dv  (pattern_dv),
      .conv_busy   (conv_busy),
      .fifo_empty  (fifo_empty),
      .fifo_full   (fifo_full),
      .level       (level),
      .overflow    (overflow),
      .drop_cnt    (drop_cnt),
      .issued_cnt  (issued_cnt)
`ifdef TRIG_TAG_EN
      ,
      .trig_tag_in (trig_tag_in),
      .tag_out     (tag_out)
`endif
   );

`ifndef TRIG_TAG_EN
   assign tag_out = 6'h0;
`endif

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Converter: busy for busy_len cycles starting the cycle after a load
   always @(posedge clk or posedge reset) begin
      if (reset) busy_cnt <= 0;
      else if (pattern_dv) busy_cnt <= busy_len;
      else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
   end
   assign conv_busy = hold_busy || (busy_cnt != 0);

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset) begin
         last_out = 4'h0;
         last_dv  = -1000;
      end else begin
         if (int'(level) > peak) peak = int'(level);
         if (pattern_dv) begin
            strobes++;
            if (exp_q.size() == 0) begin
               check("unexpected_dv", 32'(1), 32'(0));
            end else begin
               mon_e = exp_q.pop_front();
               check("order_pat", 32'(pattern_out), 32'(mon_e[3:0]));
`ifdef TRIG_TAG_EN
               check("order_tag", 32'(tag_out), 32'(mon_e[9:4]));
`endif
            end
            check("gap_ge_18", 32'((cyc - last_dv) >= 18), 32'(1));
            last_dv  = cyc;
            last_out = pattern_out;
         end else begin
            check("hold_out", 32'(pattern_out), 32'(last_out));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [3:0] p, input logic [5:0] t, input bit expect_issue);
      trig_in     = p;
      trig_tag_in = t;
      trig_in_dv  = 1'b1;
      if (expect_issue) exp_q.push_back({t, p});
      @(posedge clk);
      #1;
      trig_in_dv  = 1'b0;
   endtask

   task automatic do_reset();
      reset      = 1'b1;
      trig_in_dv = 1'b0;
      hold_busy  = 1'b0;
      exp_q.delete();
      tick(2);
      reset = 1'b0;
      tick(1);
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick(1);
         n++;
      end
      check("drain_done", 32'(exp_q.size()), 32'(0));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      trig_in     = 4'h0;
      trig_in_dv  = 1'b0;
      trig_tag_in = 6'h0;
      #1 reset = 1'b1;
      tick(2);
      check("rst_dv", 32'(pattern_dv), 32'(0));
      check("rst_out", 32'(pattern_out), 32'(0));
      check("rst_empty", 32'(fifo_empty), 32'(1));
      check("rst_full", 32'(fifo_full), 32'(0));
      check("rst_level", 32'(level), 32'(0));
      check("rst_ovf", 32'(overflow), 32'(0));
      check("rst_drop", 32'(drop_cnt), 32'(0));
      check("rst_issued", 32'(issued_cnt), 32'(0));
      reset = 1'b0;
      tick(1);

      // Single trigger: strobe exactly two clocks after the write strobe
      wr(4'hF, 6'h11, 1'b1);
      check("lat1_dv", 32'(pattern_dv), 32'(0));
      check("lat1_level", 32'(level), 32'(1));
      tick(1);
      check("lat2_dv", 32'(pattern_dv), 32'(1));
      check("lat2_out", 32'(pattern_out), 32'hF);
      check("lat2_issued", 32'(issued_cnt), 32'(1));
      check("lat2_empty", 32'(fifo_empty), 32'(1));
      tick(20);

      // Burst of three back-to-back commands
      do_reset();
      peak = 0;
      wr(4'h8, 6'h01, 1'b1);
      wr(4'h4, 6'h02, 1'b1);
      wr(4'h2, 6'h03, 1'b1);
      wait_drain(200);
      check("burst_peak", 32'(peak), 32'(2));
      check("burst_issued", 32'(issued_cnt), 32'(3));
      tick(20);

      // Overflow: 10 writes into 8 entries while the converter is held busy
      do_reset();
      hold_busy = 1'b1;
      for (int i = 0; i < 10; i++) wr(4'(i + 1), 6'(i * 3), i < 8);
      check("ovf_level", 32'(level), 32'(8));
      check("ovf_full", 32'(fifo_full), 32'(1));
      check("ovf_flag", 32'(overflow), 32'(1));
      check("ovf_drop", 32'(drop_cnt), 32'(2));
      hold_busy = 1'b0;
      wait_drain(400);
      check("ovf_issued", 32'(issued_cnt), 32'(8));
      check("ovf_sticky", 32'(overflow), 32'(1));
      tick(20);
      check("ovf_empty", 32'(fifo_empty), 32'(1));
      check("ovf_level0", 32'(level), 32'(0));

      // Zero pattern discarded at the write side
      do_reset();
      check("drop_ovf_clr", 32'(overflow), 32'(0));
      wr(4'h0, 6'h05, 1'b0);
      wr(4'h5, 6'h06, 1'b1);
      wait_drain(100);
      tick(20);
      check("drop_cnt0", 32'(drop_cnt), 32'(0));
      check("drop_issued", 32'(issued_cnt), 32'(1));

      // Write in the same cycle as an issue, then wrap the pointers
      do_reset();
      hold_busy = 1'b1;
      wr(4'hA, 6'h0A, 1'b1);
      tick(2);
      check("sim_level1", 32'(level), 32'(1));
      hold_busy = 1'b0;
      wr(4'hB, 6'h0B, 1'b1);
      check("sim_level_kept", 32'(level), 32'(1));
      check("sim_dv", 32'(pattern_dv), 32'(1));
      check("sim_out", 32'(pattern_out), 32'hA);
      for (int i = 0; i < 20; i++) begin
         wr(4'((i % 15) + 1), 6'(i * 5 + 1), 1'b1);
         tick(19);
      end
      wait_drain(300);
      check("wrap_issued", 32'(issued_cnt), 32'(22));
      tick(20);

      // Reset while waiting on the converter with three entries stored
      do_reset();
      wr(4'h3, 6'h13, 1'b1);
      wr(4'h6, 6'h16, 1'b1);
      wr(4'h9, 6'h19, 1'b1);
      wr(4'hC, 6'h1C, 1'b1);
      check("mid_level3", 32'(level), 32'(3));
      #2;
      reset = 1'b1;
      exp_q.delete();
      #1;
      check("mid_level", 32'(level), 32'(0));
      check("mid_empty", 32'(fifo_empty), 32'(1));
      check("mid_issued", 32'(issued_cnt), 32'(0));
      check("mid_out", 32'(pattern_out), 32'(0));
      tick(2);
      reset = 1'b0;
      s0 = strobes;
      tick(60);
      check("mid_no_dv", 32'(strobes), 32'(s0));

`ifdef TRIG_TAG_EN
      wr(4'hC, 6'h2A, 1'b1);
      tick(1);
      check("tag_dv", 32'(pattern_dv), 32'(1));
      check("tag_val", 32'(tag_out), 32'h2A);
      tick(25);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
